// File: rtl/mem_access_ctrl_if.sv
// ============================================================================
// Module   : mem_access_ctrl_if
// Brief    : Core request/response channel plus memory strobe bus for mem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef MEM_WORD_WIDTH
`define MEM_WORD_WIDTH 16
`endif

interface mem_access_ctrl_if #(
   parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH,
   parameter int WORD_WIDTH = `MEM_WORD_WIDTH
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [WORD_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [WORD_WIDTH-1:0] rsp_rdata;
   logic                  rsp_error;
   logic                  Read_sig;
   logic                  Write_sig;
   logic                  Mem_op_enable;
   logic [ADDR_WIDTH-1:0] Address_out;
   logic [WORD_WIDTH-1:0] Data_out;
   logic [WORD_WIDTH-1:0] Data_in;
   logic                  Mem_op_success;

   // Controller side
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
             Data_in, Mem_op_success,
      output req_ready, rsp_valid, rsp_rdata, rsp_error,
             Read_sig, Write_sig, Mem_op_enable, Address_out, Data_out
   );

   // Core and memory side
   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
             Data_in, Mem_op_success,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error,
             Read_sig, Write_sig, Mem_op_enable, Address_out, Data_out
   );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : Memory-op initiator: core valid/ready requests in, strobed
//            Read/Write/Enable protocol out, with stall retry and error response.
//            Optional statistics counters under MEM_ACCESS_CTRL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 8
`endif
`ifndef MEM_WORD_WIDTH
`define MEM_WORD_WIDTH 16
`endif

module mem_access_ctrl #(
   parameter int ADDR_WIDTH = `MEM_ADDR_WIDTH,
   parameter int WORD_WIDTH = `MEM_WORD_WIDTH,
   parameter int MAX_RETRY  = 3
) (
   input  wire logic          Global_clk,
   input  wire logic          Global_rst_n,
   mem_access_ctrl_if.slave   bus
`ifdef MEM_ACCESS_CTRL_STATS_EN
   ,
   output logic [15:0]        stat_ops,
   output logic [15:0]        stat_retries,
   output logic [15:0]        stat_errors
`endif
);

   localparam logic [3:0] MAX_RETRY_CNT = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      SAMPLE = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t                state;
   logic [3:0]            retry;
   logic                  req_ready;
   logic                  rsp_valid;
   logic [WORD_WIDTH-1:0] rsp_rdata;
   logic                  rsp_error;
   logic                  read_sig;
   logic                  write_sig;
   logic                  mem_op_enable;
   logic [ADDR_WIDTH-1:0] address_out;
   logic [WORD_WIDTH-1:0] data_out;

   // Address/data/sig registers double as the latched request; they hold across retries.
   always_ff @(posedge Global_clk or negedge Global_rst_n) begin
      if (!Global_rst_n) begin
         state         <= IDLE;
         retry         <= '0;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_error     <= 1'b0;
         read_sig      <= 1'b0;
         write_sig     <= 1'b0;
         mem_op_enable <= 1'b0;
         address_out   <= '0;
         data_out      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid && req_ready) begin
                  retry       <= '0;
                  address_out <= bus.req_addr;
                  data_out    <= bus.req_write ? bus.req_wdata : '0;
                  read_sig    <= !bus.req_write;
                  write_sig   <= bus.req_write;
                  req_ready   <= 1'b0;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               mem_op_enable <= 1'b1;
               state         <= STROBE;
            end
            STROBE: begin
               mem_op_enable <= 1'b0;
               state         <= SAMPLE;
            end
            SAMPLE: begin
               if (bus.Mem_op_success) begin
                  rsp_rdata <= write_sig ? '0 : bus.Data_in;
                  rsp_error <= 1'b0;
                  read_sig  <= 1'b0;
                  write_sig <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if (retry < MAX_RETRY_CNT) begin
                  retry <= retry + 4'd1;
                  state <= SETUP;
               end else begin
                  rsp_rdata <= '0;
                  rsp_error <= 1'b1;
                  read_sig  <= 1'b0;
                  write_sig <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               mem_op_enable <= 1'b0;
               rsp_valid     <= 1'b0;
               req_ready     <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_ACCESS_CTRL_STATS_EN
   logic rsp_fire;
   logic stall_retry;

   assign rsp_fire    = (state == RESP) && bus.rsp_ready;
   assign stall_retry = (state == SAMPLE) && !bus.Mem_op_success && (retry < MAX_RETRY_CNT);

   always_ff @(posedge Global_clk or negedge Global_rst_n) begin
      if (!Global_rst_n) begin
         stat_ops     <= '0;
         stat_retries <= '0;
         stat_errors  <= '0;
      end else begin
         if (rsp_fire && stat_ops != 16'hFFFF) begin
            stat_ops <= stat_ops + 16'd1;
         end
         if (stall_retry && stat_retries != 16'hFFFF) begin
            stat_retries <= stat_retries + 16'd1;
         end
         if (rsp_fire && rsp_error && stat_errors != 16'hFFFF) begin
            stat_errors <= stat_errors + 16'd1;
         end
      end
   end
`endif

   assign bus.req_ready     = req_ready;
   assign bus.rsp_valid     = rsp_valid;
   assign bus.rsp_rdata     = rsp_rdata;
   assign bus.rsp_error     = rsp_error;
   assign bus.Read_sig      = read_sig;
   assign bus.Write_sig     = write_sig;
   assign bus.Mem_op_enable = mem_op_enable;
   assign bus.Address_out   = address_out;
   assign bus.Data_out      = data_out;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Directed self-checking bench for mem_access_ctrl with a strobe-driven memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_WIDTH(8), .WORD_WIDTH(16)) bus ();

`ifdef MEM_ACCESS_CTRL_STATS_EN
   logic [15:0] stat_ops, stat_retries, stat_errors;
`endif

   mem_access_ctrl #(.ADDR_WIDTH(8), .WORD_WIDTH(16), .MAX_RETRY(3)) dut (
      .Global_clk   (clk),
      .Global_rst_n (rst_n),
      .bus          (bus.slave)
`ifdef MEM_ACCESS_CTRL_STATS_EN
      ,
      .stat_ops     (stat_ops),
      .stat_retries (stat_retries),
      .stat_errors  (stat_errors)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Memory model: fails the first 'stalls' strobes of each op, then succeeds.
   logic        mem_success = 1'b0;
   logic [15:0] mem_rdata   = 16'h0000;
   int          stalls  = 0;
   int          op_base = 0;
   int          pulses  = 0;
   logic        strobe_read, strobe_write;
   logic [7:0]  strobe_addr;
   logic [15:0] strobe_data;
   logic        both_seen = 1'b0;

   assign bus.Mem_op_success = mem_success;
   assign bus.Data_in        = mem_rdata;

   always @(posedge bus.Mem_op_enable) begin
      #1;
      pulses       = pulses + 1;
      strobe_read  = bus.Read_sig;
      strobe_write = bus.Write_sig;
      strobe_addr  = bus.Address_out;
      strobe_data  = bus.Data_out;
      mem_success  = ((pulses - op_base) > stalls);
   end

   always @(negedge clk) begin
      if (bus.Read_sig && bus.Write_sig) both_seen = 1'b1;
   end

   task automatic issue(input logic w, input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      op_base       = pulses;
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   // Returns the cycle index (accept cycle = 0) in which rsp_valid is seen, -1 on timeout.
   task automatic wait_rsp(output int cyc);
      cyc = 1;
      while (!bus.rsp_valid && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      if (!bus.rsp_valid) cyc = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
      n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
      n_tests++; if (bus.Mem_op_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable got %b want 0", bus.Mem_op_enable); end
      n_tests++; if ({bus.Read_sig, bus.Write_sig} !== 2'b00) begin n_fail++; $display("FAIL reset_sigs got %b want 00", {bus.Read_sig, bus.Write_sig}); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle got ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid); end
   endtask

   task automatic test_write();
      int c, p0;
      stalls = 0; mem_rdata = 16'hDEAD; p0 = pulses;
      issue(1'b1, 8'h0F, 16'hF00F);
      wait_rsp(c);
      n_tests++; if (c != 4) begin n_fail++; $display("FAIL write_latency got %0d want 4", c); end
      n_tests++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL write_pulses got %0d want 1", pulses - p0); end
      n_tests++; if ({strobe_write, strobe_read} !== 2'b10) begin n_fail++; $display("FAIL write_sigs got w/r=%b want 10", {strobe_write, strobe_read}); end
      n_tests++; if (strobe_data !== 16'hF00F) begin n_fail++; $display("FAIL write_data got %h want f00f", strobe_data); end
      n_tests++; if (strobe_addr !== 8'h0F) begin n_fail++; $display("FAIL write_addr got %h want 0f", strobe_addr); end
      n_tests++; if (bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL write_rsp got err=%b rdata=%h want 0/0000", bus.rsp_error, bus.rsp_rdata); end
      @(posedge clk);
      @(negedge clk);
      n_tests++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL write_done got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
   endtask

   task automatic test_read();
      int c, p0;
      stalls = 0; mem_rdata = 16'hF00F; p0 = pulses;
      issue(1'b0, 8'h0F, 16'h1234);
      wait_rsp(c);
      n_tests++; if (c != 4) begin n_fail++; $display("FAIL read_latency got %0d want 4", c); end
      n_tests++; if ({strobe_write, strobe_read} !== 2'b01) begin n_fail++; $display("FAIL read_sigs got w/r=%b want 01", {strobe_write, strobe_read}); end
      n_tests++; if (strobe_data !== 16'h0000) begin n_fail++; $display("FAIL read_data_out got %h want 0000", strobe_data); end
      n_tests++; if (bus.rsp_rdata !== 16'hF00F || bus.rsp_error !== 1'b0) begin n_fail++; $display("FAIL read_rsp got rdata=%h err=%b want f00f/0", bus.rsp_rdata, bus.rsp_error); end
      n_tests++; if (pulses - p0 != 1) begin n_fail++; $display("FAIL read_pulses got %0d want 1", pulses - p0); end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_stall();
      int c, p0;
      stalls = 2; mem_rdata = 16'h1234; p0 = pulses;
      issue(1'b0, 8'h33, 16'h0000);
      wait_rsp(c);
      n_tests++; if (c != 10) begin n_fail++; $display("FAIL stall_latency got %0d want 10", c); end
      n_tests++; if (pulses - p0 != 3) begin n_fail++; $display("FAIL stall_pulses got %0d want 3", pulses - p0); end
      n_tests++; if (bus.rsp_rdata !== 16'h1234 || bus.rsp_error !== 1'b0) begin n_fail++; $display("FAIL stall_rsp got rdata=%h err=%b want 1234/0", bus.rsp_rdata, bus.rsp_error); end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_retry_exhaust();
      int c, p0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      stalls = 100; mem_rdata = 16'hBEEF; p0 = pulses;
      issue(1'b0, 8'hA0, 16'h0000);
      wait_rsp(c);
      n_tests++; if (c != 13) begin n_fail++; $display("FAIL exhaust_latency got %0d want 13", c); end
      n_tests++; if (pulses - p0 != 4) begin n_fail++; $display("FAIL exhaust_pulses got %0d want 4", pulses - p0); end
      n_tests++; if (bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL exhaust_rsp got err=%b rdata=%h want 1/0000", bus.rsp_error, bus.rsp_rdata); end
      @(posedge clk);
      @(negedge clk);
`ifdef MEM_ACCESS_CTRL_STATS_EN
      n_tests++; if (stat_retries !== 16'd3) begin n_fail++; $display("FAIL stat_retries got %0d want 3", stat_retries); end
      n_tests++; if (stat_errors !== 16'd1) begin n_fail++; $display("FAIL stat_errors got %0d want 1", stat_errors); end
      n_tests++; if (stat_ops !== 16'd1) begin n_fail++; $display("FAIL stat_ops got %0d want 1", stat_ops); end
`endif
   endtask

   task automatic test_backpressure();
      int c, p0;
      stalls = 0; mem_rdata = 16'hA5A5; p0 = pulses;
      bus.rsp_ready = 1'b0;
      issue(1'b0, 8'h0F, 16'h0000);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 8'h55; bus.req_wdata = 16'h5555;
      wait_rsp(c);
      n_tests++; if (c != 4) begin n_fail++; $display("FAIL bp_latency got %0d want 4", c); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 16'hA5A5) begin n_fail++; $display("FAIL bp_hold cycle %0d got valid=%b rdata=%h want 1/a5a5", i, bus.rsp_valid, bus.rsp_rdata); end
         n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready cycle %0d got %b want 0", i, bus.req_ready); end
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_tests++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
      repeat (3) @(negedge clk);
      n_tests++; if (pulses - p0 != 1 || strobe_addr !== 8'h0F) begin n_fail++; $display("FAIL bp_busy_ignored got pulses=%0d addr=%h want 1/0f", pulses - p0, strobe_addr); end
   endtask

   task automatic test_back_to_back();
      int c;
      stalls = 0; mem_rdata = 16'h7E57;
      issue(1'b1, 8'h10, 16'h1111);
      wait_rsp(c);
      op_base = pulses;
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 8'h20; bus.req_wdata = 16'h0000;
      @(posedge clk);
      @(negedge clk);
      n_tests++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid); end
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got ready=%b want 0", bus.req_ready); end
      wait_rsp(c);
      n_tests++; if (c != 4) begin n_fail++; $display("FAIL b2b_latency got %0d want 4", c); end
      n_tests++; if (strobe_addr !== 8'h20 || strobe_read !== 1'b1 || bus.rsp_rdata !== 16'h7E57) begin n_fail++; $display("FAIL b2b_second got addr=%h rd=%b rdata=%h want 20/1/7e57", strobe_addr, strobe_read, bus.rsp_rdata); end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      logic seen;
      stalls = 0; mem_rdata = 16'h0BAD; seen = 1'b0;
      issue(1'b0, 8'h44, 16'h0000);
      @(negedge clk);
      n_tests++; if (bus.Mem_op_enable !== 1'b1) begin n_fail++; $display("FAIL midop_in_strobe got enable=%b want 1", bus.Mem_op_enable); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (bus.Mem_op_enable !== 1'b0 || bus.Read_sig !== 1'b0) begin n_fail++; $display("FAIL midop_enable_drop got en=%b rd=%b want 0/0", bus.Mem_op_enable, bus.Read_sig); end
      n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midop_req_ready got %b want 1", bus.req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (bus.rsp_valid) seen = 1'b1;
      end
      n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midop_no_response got rsp_valid seen=%b want 0", seen); end
   endtask

   task automatic test_exclusive();
      n_tests++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL sigs_exclusive got both_seen=%b want 0", both_seen); end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = 8'h00;
      bus.req_wdata = 16'h0000;
      bus.rsp_ready = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_stall();
      test_retry_exhaust();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      test_exclusive();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator side of the memory-op interface. It accepts read/write requests from the co-processor core over a valid/ready handshake and drives the memory unit's Read_sig/Write_sig/Address/Data/Mem_op_enable strobe protocol. It samples Mem_op_success, retries stalled ops, and returns read data or an error to the core over a valid/ready response channel.

Parameters:
ADDR_WIDTH, `MEM_ADDR_WIDTH, memory address width
WORD_WIDTH, `MEM_WORD_WIDTH (16), memory word width
MAX_RETRY, 3, re-strobes allowed after a stall before reporting an error (0..15)

Ports:
Global_clk  in  1  system clock; all state changes on its rising edge
Global_rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  controller can accept a request
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  WORD_WIDTH  write data
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts response
rsp_rdata  out  WORD_WIDTH  read data; 0 for writes and errors
rsp_error  out  1  op failed after MAX_RETRY retries
Read_sig  out  1  to memory: read op
Write_sig  out  1  to memory: write op
Mem_op_enable  out  1  to memory: op strobe; memory acts on its rising edge
Address_out  out  ADDR_WIDTH  to memory: address
Data_out  out  WORD_WIDTH  to memory: write data
Data_in  in  WORD_WIDTH  from memory: read data
Mem_op_success  in  1  from memory: last op completed

Behaviour:
- All outputs registered (Moore). Reset (async, Global_rst_n=0): state IDLE; req_ready=1; everything else 0, including retry count.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write/addr/wdata, clear retry count, go SETUP. req_ready=0 in every other state.
- SETUP (1 cycle): drive Address_out and Data_out (wdata for writes, 0 for reads). Read_sig=!write, Write_sig=write. Mem_op_enable=0. Go STROBE.
- STROBE (1 cycle): Mem_op_enable=1 with address, data and sigs held. Go SAMPLE.
- SAMPLE (1 cycle): Mem_op_enable=0, sigs held. At the end of the cycle, sample Mem_op_success:
  - 1: capture Data_in into rsp_rdata (reads only), rsp_error=0, go RESP.
  - 0 and retry<MAX_RETRY: retry+=1, go SETUP. Enable must go low for ≥1 cycle between strobes.
  - 0 and retry==MAX_RETRY: rsp_error=1, rsp_rdata=0, go RESP.
- RESP: Read_sig=Write_sig=0, rsp_valid=1. rsp_rdata/rsp_error stable until rsp_valid&&rsp_ready, then go IDLE with rsp_valid=0.
- Latency with no stall and rsp_ready=1: request accepted at edge N; rsp_valid is high in cycle N+4. Each stall adds 3 cycles. Next request can be accepted in cycle N+5 (no combinational ready→valid path).
- Read_sig and Write_sig are never both 1. Exactly one rising edge of Mem_op_enable per attempt.
- Mem_op_success is never sampled in IDLE/SETUP/STROBE; a stale value from a prior op is ignored.
- Reset asserted mid-op: immediate return to reset values. Mem_op_enable falls with no completion signalled, and the in-flight op is dropped.
- req_valid while busy: ignored and held off by req_ready=0. Request fields are only read at the handshake.

Optional Feature:
Macro MEM_ACCESS_CTRL_STATS_EN.
- Defined: adds output ports stat_ops (16-bit; +1 per response handshake), stat_retries (16-bit; +1 per SAMPLE stall that re-strobes) and stat_errors (16-bit; +1 per error response). All saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold Global_rst_n=0 → req_ready=1; rsp_valid, Mem_op_enable, Read_sig, Write_sig all 0. Release → still IDLE.
- Write: req_write=1, addr=8'h0F, wdata=16'hF00F, memory success=1 → one enable pulse with Write_sig=1, Data_out=F00F; rsp_valid at N+4, rsp_error=0, rsp_rdata=0.
- Read: addr=8'h0F, memory returns 16'hF00F with success=1 → Read_sig=1 during the strobe; rsp_rdata=F00F, rsp_error=0.
- Stall then success: memory success=0 on attempts 1–2, 1 on attempt 3 → three enable pulses separated by low cycles; rsp_valid at N+10, rsp_error=0.
- Retries exhausted: success always 0, MAX_RETRY=3 → exactly 4 enable pulses, then rsp_error=1, rsp_rdata=0. With STATS_EN: stat_retries=3, stat_errors=1.
- Backpressure and reset: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0. Separately, assert reset during STROBE → Mem_op_enable=0 immediately and no response is produced.
